checkpoint_mailbox: RTL and testbench
=====================================

# checkpoint_mailbox

Per-core Avalon-MM slave at the receiving end of the fingerprint checkpoint path. It accepts checkpoint writes issued by the checkpoint unit into the core's `CHECKPOINT_OFFSET` window and decodes them into {physical core id, task id} records. Records are queued in a small FIFO and signalled to the Nios core by an interrupt. The core drains the queue through a register port; when the queue is full, the block back-pressures the checkpoint unit with waitrequest.

## Interface
Parameters:
- KEY_WIDTH, default `CRC_KEY_WIDTH`: width of the task id field and of the core id field.
- DEPTH, default `CRC_KEY_SIZE`: number of FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ckpt_write  in  1  inbound checkpoint write strobe.
- ckpt_writedata  in  `NIOS_DATA_WIDTH`  checkpoint word: bit 2·KEY_WIDTH is the valid marker (0x100 for KEY_WIDTH=4); bits [2·KEY_WIDTH-1:KEY_WIDTH] are the core id; bits [KEY_WIDTH-1:0] are the task id.
- ckpt_waitrequest  out  1  stall for the inbound write.
- cpu_address  in  2  word address of the register port.
- cpu_read  in  1  register read strobe.
- cpu_write  in  1  register write strobe.
- cpu_writedata  in  32  register write data.
- cpu_readdata  out  32  register read data; fixed read latency 1.
- irq  out  1  level interrupt to the core.

## Operation
- Push:
  - Accept when ckpt_write=1 and ckpt_waitrequest=0.
  - If the marker bit is 1, push {core id, task id} into the FIFO.
  - If the marker bit is 0, drop the write, set the sticky `malformed` flag, and do not push.
- ckpt_waitrequest = full; purely combinational from registered state.
  - A write held under waitrequest must present stable data (Avalon rule); the block does not latch it.
- Register map (word addresses):
  - 0 STATUS (RO): bit0 nonempty, bit1 full, bit2 malformed, bit3 irq_en, bits[15:8] count.
  - 1 POP (RO, read side effect):
    - If nonempty: return {marker=1 at bit 2·KEY_WIDTH, core id, task id} and pop one entry.
    - If empty: return 0 and do not pop.
  - 2 CTRL (RW):
    - Write: bit0 sets irq_en; writing 1 to bit1 clears `malformed`.
    - Read: returns {30'b0, 0, irq_en}.
  - 3: reserved; reads return 0 and writes are ignored.
- cpu_read and cpu_write asserted together: the write takes effect and readdata is 0.
- Register irq each cycle as irq_en && count≠0.
- Arithmetic:
  - count is log2(DEPTH)+1 bits wide.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is zero-extended into STATUS.

## Timing
- Reset values: irq=0, cpu_readdata=0, ckpt_waitrequest=0, count=0, irq_en=0, malformed=0, and both pointers are 0.
- Push accepted at edge N: count and full reflect it after edge N. irq rises after edge N+1 (2 cycles after the write) when irq_en=1.
- POP read presented at edge N: cpu_readdata is valid after edge N, i.e. in cycle N+1, and count decrements at the same edge.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - When empty, the pop returns 0 and the push lands.
  - When full, waitrequest blocks the push. The pop frees a slot, waitrequest drops in the next cycle, and the push is accepted then.
- Back-to-back POP reads, one per cycle, each pop a distinct entry in FIFO order.
- A reset asserted mid-transfer discards all queued entries and flags. It also drops waitrequest in the following cycle.

## Structure
- Widths and offsets come from `defines.v`: `NIOS_DATA_WIDTH`, `CRC_KEY_WIDTH`, `CRC_KEY_SIZE`. Add `CKPT_MBOX_STATUS`, `CKPT_MBOX_POP` and `CKPT_MBOX_CTRL` there as address constants.
- One sub-module: `ckpt_mbox_fifo`, a synchronous-reset FIFO of width 2·KEY_WIDTH and depth DEPTH.
  - Outputs: data_out (show-ahead), empty, full, count.
  - The top level holds the register decode, the flags and the irq.

## Test plan
1. Reset, then set CTRL=1 and write 0x123 (core 2, task 3) → STATUS.count=1 and irq=1 two cycles later. POP returns 0x123 → count=0 and irq=0 one cycle after the count drops.
2. Write 0x023 (marker 0) → no push, count=0, STATUS bit2=1. CTRL write 0x3 → bit2=0.
3. Sixteen writes 0x100–0x10F fill the FIFO → full=1. A seventeenth write 0x1AA is held under waitrequest. One POP returns 0x100, the held write completes the next cycle, and draining then yields 0x101…0x10F, 0x1AA.
4. Empty FIFO, POP issued in the same cycle as write 0x155 → readdata=0, then count=1 and the next POP returns 0x155.
5. Wrap-around: 40 interleaved push/pop pairs with tasks 0..F cycling → data matches order, count never exceeds 1, and pointers wrap cleanly.
6. Queue 5 entries, then pulse reset while waitrequest=0 and a POP is in flight → count=0, irq=0, readdata=0, and a following POP returns 0.

Source files
------------

// File: rtl/checkpoint_mailbox_pkg.sv
// Shared widths, register addresses and bit positions for the checkpoint mailbox.
`ifndef CHECKPOINT_MAILBOX_DEFINES
`define CHECKPOINT_MAILBOX_DEFINES
`define NIOS_DATA_WIDTH 32
`define CRC_KEY_WIDTH 4
`define CRC_KEY_SIZE 16
`define CKPT_MBOX_STATUS 2'd0
`define CKPT_MBOX_POP 2'd1
`define CKPT_MBOX_CTRL 2'd2
`endif

package checkpoint_mailbox_pkg;

  localparam int CPU_DATA_W = 32;

  // STATUS register bit positions
  localparam int STATUS_NONEMPTY  = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_MALFORMED = 2;
  localparam int STATUS_IRQ_EN    = 3;
  localparam int STATUS_COUNT_LSB = 8;

  // CTRL register bit positions
  localparam int CTRL_IRQ_EN       = 0;
  localparam int CTRL_CLR_MALFORMED = 1;

  typedef enum logic [1:0] {
    REG_STATUS = `CKPT_MBOX_STATUS,
    REG_POP    = `CKPT_MBOX_POP,
    REG_CTRL   = `CKPT_MBOX_CTRL,
    REG_RSVD   = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/ckpt_mbox_fifo.sv
// Show-ahead FIFO holding decoded {core id, task id} checkpoint records.
module ckpt_mbox_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign data_out = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count only moves when exactly one side is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/checkpoint_mailbox.sv
// Avalon-MM mailbox: queues inbound checkpoint records and exposes them to the Nios core.
module checkpoint_mailbox
  import checkpoint_mailbox_pkg::*;
#(
  parameter int KEY_WIDTH = `CRC_KEY_WIDTH,
  parameter int DEPTH     = `CRC_KEY_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ckpt_write,
  input  logic [`NIOS_DATA_WIDTH-1:0]  ckpt_writedata,
  output logic                         ckpt_waitrequest,
  input  logic [1:0]                   cpu_address,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  input  logic [CPU_DATA_W-1:0]        cpu_writedata,
  output logic [CPU_DATA_W-1:0]        cpu_readdata,
  output logic                         irq
);

  localparam int REC_W = 2 * KEY_WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [REC_W-1:0] rec_out;
  logic             accept;
  logic             marker;
  logic             push;
  logic             drop;
  logic             rd_en;
  logic             pop;
  logic             ctrl_write;
  logic             irq_en;
  logic             malformed;
  logic [CPU_DATA_W-1:0] read_word;
  logic             unused_bits;

  assign ckpt_waitrequest = full;
  assign accept     = ckpt_write && !full;
  assign marker     = ckpt_writedata[REC_W];
  assign push       = accept && marker;
  assign drop       = accept && !marker;
  assign rd_en      = cpu_read && !cpu_write;
  assign pop        = rd_en && (cpu_address == REG_POP) && !empty;
  assign ctrl_write = cpu_write && (cpu_address == REG_CTRL);
  assign unused_bits = ^{1'b0, ckpt_writedata[`NIOS_DATA_WIDTH-1:REC_W+1],
                         cpu_writedata[CPU_DATA_W-1:2]};

  ckpt_mbox_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (ckpt_writedata[REC_W-1:0]),
    .data_out (rec_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // Register read decode; a POP on an empty queue and the reserved address read as zero.
  always_comb begin
    read_word = '0;
    case (cpu_address)
      REG_STATUS: begin
        read_word[STATUS_NONEMPTY]  = !empty;
        read_word[STATUS_FULL]      = full;
        read_word[STATUS_MALFORMED] = malformed;
        read_word[STATUS_IRQ_EN]    = irq_en;
        read_word[STATUS_COUNT_LSB +: 8] = 8'(count);
      end
      REG_POP: begin
        if (!empty) begin
          read_word[REC_W]       = 1'b1;
          read_word[REC_W-1:0]   = rec_out;
        end
      end
      REG_CTRL: read_word[CTRL_IRQ_EN] = irq_en;
      default:  read_word = '0;
    endcase
  end

  // Read data, control flags and the level interrupt; a drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_readdata <= '0;
      irq          <= 1'b0;
      irq_en       <= 1'b0;
      malformed    <= 1'b0;
    end else begin
      cpu_readdata <= rd_en ? read_word : '0;
      irq          <= irq_en && (count != '0);
      if (ctrl_write) irq_en <= cpu_writedata[CTRL_IRQ_EN];
      if (drop)
        malformed <= 1'b1;
      else if (ctrl_write && cpu_writedata[CTRL_CLR_MALFORMED])
        malformed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_checkpoint_mailbox.sv
// Directed self-checking bench for checkpoint_mailbox.
module tb_checkpoint_mailbox;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_POP    = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ckpt_write;
  logic [31:0] ckpt_writedata;
  logic        ckpt_waitrequest;
  logic [1:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  checkpoint_mailbox dut (
    .clk              (clk),
    .reset            (reset),
    .ckpt_write       (ckpt_write),
    .ckpt_writedata   (ckpt_writedata),
    .ckpt_waitrequest (ckpt_waitrequest),
    .cpu_address      (cpu_address),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_writedata    (cpu_writedata),
    .cpu_readdata     (cpu_readdata),
    .irq              (irq)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock once, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] wd,
                               input logic rd, input logic cw,
                               input logic [1:0] addr, input logic [31:0] cwd,
                               input logic rst);
    reset          = rst;
    ckpt_write     = wr;
    ckpt_writedata = wd;
    cpu_read       = rd;
    cpu_write      = cw;
    cpu_address    = addr;
    cpu_writedata  = cwd;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    ckpt_write     = 1'b0;
    ckpt_writedata = '0;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_address    = '0;
    cpu_writedata  = '0;
  endtask

  // Compare one observed value against its hand-derived expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ckptWrite(input logic [31:0] wd);
    applyStimulus(1'b1, wd, 1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
  endtask

  task automatic cpuRead(input logic [1:0] addr);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, addr, 32'h0, 1'b0);
  endtask

  task automatic cpuWrite(input logic [1:0] addr, input logic [31:0] cwd);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, addr, cwd, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, A_STATUS, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] wrapWord(input int i);
    return 32'h100 | (32'((i / 16) % 16) << 4) | 32'(i % 16);
  endfunction

  initial begin
    reset = 1'b1; ckpt_write = 1'b0; ckpt_writedata = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;

    // Reset state
    $display("[TB] reset");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, A_STATUS, 32'h0, 1'b1);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_readdata", cpu_readdata, 32'h0);
    checkOutput("rst_waitreq", {31'b0, ckpt_waitrequest}, 32'h0);
    cpuRead(A_STATUS);
    checkOutput("rst_status", cpu_readdata, 32'h0);

    // Single push, interrupt, pop
    $display("[TB] single push/pop");
    cpuWrite(A_CTRL, 32'h1);
    ckptWrite(32'h123);
    checkOutput("t1_irq_not_yet", {31'b0, irq}, 32'h0);
    cpuRead(A_STATUS);
    checkOutput("t1_status", cpu_readdata, 32'h0000_0109);
    checkOutput("t1_irq_high", {31'b0, irq}, 32'h1);
    cpuRead(A_POP);
    checkOutput("t1_pop", cpu_readdata, 32'h123);
    checkOutput("t1_irq_lag", {31'b0, irq}, 32'h1);
    idle();
    checkOutput("t1_irq_low", {31'b0, irq}, 32'h0);

    // Malformed write is dropped and flagged
    $display("[TB] malformed");
    ckptWrite(32'h023);
    cpuRead(A_STATUS);
    checkOutput("t2_status_mal", cpu_readdata, 32'h0000_000C);
    cpuWrite(A_CTRL, 32'h3);
    cpuRead(A_STATUS);
    checkOutput("t2_status_clr", cpu_readdata, 32'h0000_0008);
    cpuRead(A_CTRL);
    checkOutput("t2_ctrl", cpu_readdata, 32'h1);

    // Fill, back-pressure, release, drain
    $display("[TB] full and back-pressure");
    for (int i = 0; i < 16; i++) ckptWrite(32'h100 + 32'(i));
    checkOutput("t3_waitreq_full", {31'b0, ckpt_waitrequest}, 32'h1);
    cpuRead(A_STATUS);
    checkOutput("t3_status_full", cpu_readdata, 32'h0000_100B);
    ckptWrite(32'h1AA);
    checkOutput("t3_waitreq_held", {31'b0, ckpt_waitrequest}, 32'h1);
    applyStimulus(1'b1, 32'h1AA, 1'b1, 1'b0, A_POP, 32'h0, 1'b0);
    checkOutput("t3_pop_first", cpu_readdata, 32'h100);
    checkOutput("t3_waitreq_drop", {31'b0, ckpt_waitrequest}, 32'h0);
    ckptWrite(32'h1AA);
    checkOutput("t3_waitreq_refull", {31'b0, ckpt_waitrequest}, 32'h1);
    for (int i = 1; i < 16; i++) begin
      cpuRead(A_POP);
      checkOutput("t3_drain", cpu_readdata, 32'h100 + 32'(i));
    end
    cpuRead(A_POP);
    checkOutput("t3_drain_held", cpu_readdata, 32'h1AA);
    cpuRead(A_STATUS);
    checkOutput("t3_status_empty", cpu_readdata, 32'h0000_0008);

    // Pop on empty queue in the same cycle as a push
    $display("[TB] simultaneous push/pop on empty");
    applyStimulus(1'b1, 32'h155, 1'b1, 1'b0, A_POP, 32'h0, 1'b0);
    checkOutput("t4_pop_empty", cpu_readdata, 32'h0);
    cpuRead(A_STATUS);
    checkOutput("t4_status", cpu_readdata, 32'h0000_0109);
    cpuRead(A_POP);
    checkOutput("t4_pop", cpu_readdata, 32'h155);

    // Interleaved push/pop across pointer wrap
    $display("[TB] wrap-around");
    ckptWrite(wrapWord(0));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, wrapWord(i + 1), 1'b1, 1'b0, A_POP, 32'h0, 1'b0);
      checkOutput("t5_pop", cpu_readdata, wrapWord(i));
    end
    cpuRead(A_STATUS);
    checkOutput("t5_status_one", cpu_readdata, 32'h0000_0109);
    cpuRead(A_POP);
    checkOutput("t5_pop_last", cpu_readdata, wrapWord(40));
    cpuRead(A_STATUS);
    checkOutput("t5_status_empty", cpu_readdata, 32'h0000_0008);

    // Reserved address and read+write collision
    $display("[TB] reserved and collision");
    cpuRead(A_RSVD);
    checkOutput("rsvd_read", cpu_readdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, A_CTRL, 32'h0, 1'b0);
    checkOutput("rw_collision", cpu_readdata, 32'h0);
    cpuRead(A_CTRL);
    checkOutput("rw_ctrl_written", cpu_readdata, 32'h0);
    cpuWrite(A_CTRL, 32'h1);

    // Reset in the middle of traffic
    $display("[TB] mid-transfer reset");
    for (int i = 1; i <= 5; i++) ckptWrite(32'h100 + 32'(i));
    cpuRead(A_STATUS);
    checkOutput("t6_status_five", cpu_readdata, 32'h0000_0509);
    checkOutput("t6_irq_before", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, A_POP, 32'h0, 1'b1);
    checkOutput("t6_readdata", cpu_readdata, 32'h0);
    checkOutput("t6_irq", {31'b0, irq}, 32'h0);
    checkOutput("t6_waitreq", {31'b0, ckpt_waitrequest}, 32'h0);
    cpuRead(A_STATUS);
    checkOutput("t6_status", cpu_readdata, 32'h0);
    cpuRead(A_POP);
    checkOutput("t6_pop", cpu_readdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
